// File: rtl/obi_master_pipe_pkg.sv
// Shared types for obi_master_pipe: A-phase state encoding, response tag layout
// and small helper functions.
package obi_master_pkg;

   typedef enum logic [0:0] {
      A_IDLE = 1'b0,
      A_REQ  = 1'b1
   } a_state_e;

   // The data-width-dependent part of a response is added by a module-level typedef.
   typedef struct packed {
      logic err;
      logic we;
   } rsp_tag_t;

   localparam int unsigned ERR_CNT_W = 8;

   function automatic logic [ERR_CNT_W-1:0] sat_inc8(input logic [ERR_CNT_W-1:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 32'd1) ? $clog2(depth) : 32'd1;
   endfunction

endpackage

// File: rtl/obi_master_pipe_if.sv
// OBI A/R channel bundle between obi_master_pipe (master) and the bus (slave).
interface obi_master_pipe_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    req;
   logic                    gnt;
   logic [ADDR_WIDTH-1:0]   addr;
   logic                    we;
   logic [DATA_WIDTH/8-1:0] be;
   logic [DATA_WIDTH-1:0]   wdata;
   logic                    rvalid;
   logic                    rready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    err;

   modport master (
      output req, addr, we, be, wdata, rready,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr, we, be, wdata, rready,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/obi_master_pipe_rsp_fifo.sv
// obi_rsp_fifo: first-word fall-through in-order FIFO; a push on a full FIFO is
// accepted when a pop happens in the same cycle.
module obi_rsp_fifo
   import obi_master_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o
);
   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push_s;
   logic             do_pop_s;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + {{(PW-1){1'b0}}, 1'b1};
   endfunction

   assign do_pop_s  = pop_i && (count_q != {CW{1'b0}});
   assign do_push_s = push_i && ((count_q != CW'(DEPTH)) || do_pop_s);
   assign rdata_o   = mem_q[rptr_q];
   assign empty_o   = (count_q == {CW{1'b0}});

   // Storage, pointers and occupancy.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wptr_q  <= {PW{1'b0}};
         rptr_q  <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= next_ptr(wptr_q);
         end
         if (do_pop_s) begin
            rptr_q <= next_ptr(rptr_q);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_q <= count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/obi_master_pipe.sv
// obi_master_pipe: pipelined OBI master with one-entry A-phase buffer, credit
// counter and in-order response FIFO. Optional: OBI_MASTER_PIPE_ERRCNT_EN adds err_cnt_o.
module obi_master_pipe
   import obi_master_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_OUTST  = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    cmd_req_i,
   output logic                    cmd_gnt_o,
   input  logic                    cmd_we_i,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
   input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    rsp_we_o,
   obi_master_pipe_if.master       obi,
`ifdef OBI_MASTER_PIPE_ERRCNT_EN
   output logic [ERR_CNT_W-1:0]    err_cnt_o,
`endif
   output logic                    spurious_o
);
   localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
   localparam int unsigned BE_W  = DATA_WIDTH / 8;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
      rsp_tag_t              tag;
   } rsp_t;

   a_state_e              state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [BE_W-1:0]       be_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic                  rready_q;
   logic                  spurious_q;

   logic accept_s;
   logic a_gnt_s;
   logic pop_s;
   logic r_beat_s;
   logic r_spur_s;
   logic tag_we_s;
   logic tag_empty_s;
   logic rsp_empty_s;
   rsp_t rsp_push_s;
   rsp_t rsp_head_s;

   assign cmd_gnt_o = ((state_q == A_IDLE) || obi.gnt) && (cnt_q < CNT_W'(MAX_OUTST));
   assign accept_s  = cmd_req_i && cmd_gnt_o;
   assign a_gnt_s   = (state_q == A_REQ) && obi.gnt;
   assign pop_s     = rsp_valid_o && rsp_ready_i;

   // A beat only counts if a granted command is still waiting for its answer.
   assign r_beat_s = obi.rvalid && rready_q && !tag_empty_s;
   assign r_spur_s = obi.rvalid && rready_q && tag_empty_s;

   assign obi.req    = (state_q == A_REQ);
   assign obi.addr   = addr_q;
   assign obi.we     = we_q;
   assign obi.be     = be_q;
   assign obi.wdata  = wdata_q;
   assign obi.rready = rready_q;

   assign rsp_valid_o = !rsp_empty_s;
   assign rsp_rdata_o = rsp_head_s.rdata;
   assign rsp_err_o   = rsp_head_s.tag.err;
   assign rsp_we_o    = rsp_head_s.tag.we;
   assign spurious_o  = spurious_q;

   // Credit count: accepted commands whose response has not yet been popped.
   always_comb begin
      cnt_d = cnt_q;
      case ({accept_s, pop_s})
         2'b10:   cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         2'b01:   cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
         default: cnt_d = cnt_q;
      endcase
   end

   // Response record; write responses never carry bus data.
   always_comb begin
      rsp_push_s         = '{rdata: {DATA_WIDTH{1'b0}}, tag: '{err: 1'b0, we: 1'b0}};
      rsp_push_s.tag.err = obi.err;
      rsp_push_s.tag.we  = tag_we_s;
      if (tag_we_s) begin
         rsp_push_s.rdata = {DATA_WIDTH{1'b0}};
      end else begin
         rsp_push_s.rdata = obi.rdata;
      end
   end

   // A-phase FSM and command buffer; buffer holds until the bus grants it.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= A_IDLE;
         addr_q  <= {ADDR_WIDTH{1'b0}};
         we_q    <= 1'b0;
         be_q    <= {BE_W{1'b0}};
         wdata_q <= {DATA_WIDTH{1'b0}};
      end else begin
         if (accept_s) begin
            addr_q  <= cmd_addr_i;
            we_q    <= cmd_we_i;
            be_q    <= cmd_be_i;
            wdata_q <= cmd_wdata_i;
         end
         case (state_q)
            A_IDLE:  state_q <= accept_s ? A_REQ : A_IDLE;
            A_REQ:   state_q <= (accept_s || !obi.gnt) ? A_REQ : A_IDLE;
            default: state_q <= A_IDLE;
         endcase
      end
   end

   // Credit counter, R-channel ready and sticky spurious flag.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q      <= {CNT_W{1'b0}};
         rready_q   <= 1'b0;
         spurious_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         rready_q   <= 1'b1;
         spurious_q <= spurious_q || r_spur_s;
      end
   end

`ifdef OBI_MASTER_PIPE_ERRCNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q;

   // Saturating count of error responses.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         err_cnt_q <= {ERR_CNT_W{1'b0}};
      end else if (r_beat_s && obi.err) begin
         err_cnt_q <= sat_inc8(err_cnt_q);
      end else begin
         err_cnt_q <= err_cnt_q;
      end
   end

   assign err_cnt_o = err_cnt_q;
`endif

   obi_rsp_fifo #(
      .WIDTH (1),
      .DEPTH (MAX_OUTST)
   ) u_tag_q (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (a_gnt_s),
      .wdata_i (we_q),
      .pop_i   (r_beat_s),
      .rdata_o (tag_we_s),
      .empty_o (tag_empty_s)
   );

   obi_rsp_fifo #(
      .WIDTH ($bits(rsp_t)),
      .DEPTH (MAX_OUTST)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (r_beat_s),
      .wdata_i (rsp_push_s),
      .pop_i   (pop_s),
      .rdata_o (rsp_head_s),
      .empty_o (rsp_empty_s)
   );
endmodule
